// File: rtl/sd_cmd_rx.sv
// sd_cmd_rx -- SD-bus CMD-line response receiver.
//
// Armed by the command sequencer once it has released CMD. Waits for the
// card's start bit, deserialises a 48-bit (R1/R3/R6/R7) or 136-bit (R2)
// response MSB-first on SDCLK rising strobes, checks CRC7, the transmission
// bit and the end bit, and enforces the N_CR start-bit timeout.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   sdclk_rise_i  one-cycle strobe at the SDCLK rising edge (CMD sample point)
//   cmd_i         CMD line input
//   start_i       arm pulse, honoured only while idle
//   long_i        captured with start_i: 1 = 136-bit R2, 0 = 48-bit
//   crc_check_i   captured with start_i: 0 suppresses the CRC check (R3)
//   busy_o        high from the accepted start_i through the done_o cycle
//   done_o        one-cycle completion pulse
//   resp_o        payload: short = bits [47:8] in [39:0]; long = bits [127:0]
//   index_o       short: bits [45:40]; long: 6'h3F
//   crc_err_o     CRC7 mismatch (only when the check is enabled)
//   frame_err_o   transmission bit set or end bit clear
//   timeout_o     no start bit within TIMEOUT_CLKS strobes
module sd_cmd_rx #(
    parameter int TIMEOUT_CLKS = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sdclk_rise_i,
    input  logic         cmd_i,
    input  logic         start_i,
    input  logic         long_i,
    input  logic         crc_check_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] resp_o,
    output logic [5:0]   index_o,
    output logic         crc_err_o,
    output logic         frame_err_o,
    output logic         timeout_o
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic          long_q;
    logic          crc_chk_q;
    logic          trans_q;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    bit_cnt;
    logic [126:0]  shreg;
    logic [6:0]    crc;

    logic [127:0]  shreg_nxt;
    logic [7:0]    bit_cnt_nxt;
    logic [TW-1:0] tmo_nxt;
    logic          crc_en;
    logic          last_bit;

    // Serial CRC7, generator x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Only 127 bits are stored: the newest 128 bits (including the one being
    // sampled now) are all a long frame needs; its header byte is either
    // constant or captured separately (transmission bit).
    assign shreg_nxt   = {shreg, cmd_i};
    assign bit_cnt_nxt = bit_cnt + 8'd1;
    assign tmo_nxt     = tmo_cnt + TW'(1);
    assign last_bit    = long_q ? (bit_cnt_nxt == 8'd136) : (bit_cnt_nxt == 8'd48);

    // bit_cnt_nxt is the 1-based position of the bit being sampled. Short
    // frames cover positions 1..40 (bits 47:8); long frames skip the 8-bit
    // header and cover positions 9..128 (bits 127:8). The start bit is zero
    // and leaves a zero CRC register unchanged, so it needs no update.
    always_comb begin
        crc_en = 1'b0;
        if (long_q) begin
            crc_en = (bit_cnt_nxt >= 8'd9) && (bit_cnt_nxt <= 8'd128);
        end else begin
            crc_en = (bit_cnt_nxt <= 8'd40);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            resp_o      <= '0;
            index_o     <= '0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        long_q      <= long_i;
                        crc_chk_q   <= crc_check_i;
                        trans_q     <= 1'b0;
                        tmo_cnt     <= '0;
                        bit_cnt     <= '0;
                        shreg       <= '0;
                        crc         <= '0;
                        resp_o      <= '0;
                        index_o     <= '0;
                        crc_err_o   <= 1'b0;
                        frame_err_o <= 1'b0;
                        timeout_o   <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (sdclk_rise_i) begin
                        // A start bit on the final allowed strobe still wins.
                        if (!cmd_i) begin
                            shreg   <= shreg_nxt[126:0];
                            bit_cnt <= 8'd1;
                            state   <= S_RECV;
                        end else begin
                            tmo_cnt <= tmo_nxt;
                            if (tmo_nxt == TW'(TIMEOUT_CLKS)) begin
                                timeout_o <= 1'b1;
                                done_o    <= 1'b1;
                                state     <= S_DONE;
                            end
                        end
                    end
                end

                S_RECV: begin
                    if (sdclk_rise_i) begin
                        shreg   <= shreg_nxt[126:0];
                        bit_cnt <= bit_cnt_nxt;
                        if (crc_en) begin
                            crc <= crc7_step(crc, cmd_i);
                        end
                        // The transmission bit is always the second bit on the wire.
                        if (bit_cnt_nxt == 8'd2) begin
                            trans_q <= cmd_i;
                        end
                        // Results are registered on the end-bit strobe so they
                        // are valid together with done_o in the DONE cycle.
                        if (last_bit) begin
                            if (long_q) begin
                                resp_o  <= shreg_nxt;
                                index_o <= 6'h3F;
                            end else begin
                                resp_o  <= {88'd0, shreg_nxt[47:8]};
                                index_o <= shreg_nxt[45:40];
                            end
                            crc_err_o   <= crc_chk_q && (crc != shreg_nxt[7:1]);
                            frame_err_o <= trans_q || !shreg_nxt[0];
                            done_o      <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_rx.sv
// tb_sd_cmd_rx -- self-checking bench for sd_cmd_rx.
//
// Frames are built from field values with the CRC obtained by polynomial
// long division; expected outputs come from the frame layout rules.
module tb_sd_cmd_rx;

    logic         clk = 1'b0;
    logic         rst;
    logic         sdclk_rise;
    logic         cmd;
    logic         start;
    logic         lng;
    logic         chk;
    logic         busy;
    logic         done;
    logic [127:0] resp;
    logic [5:0]   index;
    logic         crc_err;
    logic         frame_err;
    logic         timeout;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    sd_cmd_rx #(.TIMEOUT_CLKS(64)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sdclk_rise_i (sdclk_rise),
        .cmd_i        (cmd),
        .start_i      (start),
        .long_i       (lng),
        .crc_check_i  (chk),
        .busy_o       (busy),
        .done_o       (done),
        .resp_o       (resp),
        .index_o      (index),
        .crc_err_o    (crc_err),
        .frame_err_o  (frame_err),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    // Counts done pulses seen so far (value before each edge).
    always @(posedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [127:0] resp;
        logic [5:0]   index;
        logic         crc_err;
        logic         frame_err;
    } exp_t;

    // CRC7 as remainder of (message * x^7) mod (x^7 + x^3 + 1).
    function automatic logic [6:0] crc7_div(input logic [135:0] f, input logic l);
        logic [127:0] m;
        int top;
        m = '0;
        if (l) begin
            m   = {1'b0, f[127:8], 7'b0};
            top = 126;
        end else begin
            m[46:0] = {f[47:8], 7'b0};
            top     = 46;
        end
        for (int i = top; i >= 7; i--) begin
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        end
        return m[6:0];
    endfunction

    function automatic logic [135:0] make_short(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] f;
        f        = '0;
        f[45:40] = idx;
        f[39:8]  = arg;
        f[7:1]   = crc7_div(f, 1'b0);
        f[0]     = 1'b1;
        return f;
    endfunction

    function automatic logic [135:0] make_long(input logic [119:0] body);
        logic [135:0] f;
        f          = '0;
        f[135:128] = 8'h3F;
        f[127:8]   = body;
        f[7:1]     = crc7_div(f, 1'b1);
        f[0]       = 1'b1;
        return f;
    endfunction

    function automatic exp_t model(input logic [135:0] f, input logic l, input logic c);
        exp_t e;
        if (l) begin
            e.resp      = f[127:0];
            e.index     = 6'h3F;
            e.frame_err = f[134] || !f[0];
        end else begin
            e.resp      = {88'd0, f[47:8]};
            e.index     = f[45:40];
            e.frame_err = f[46] || !f[0];
        end
        e.crc_err = c && (crc7_div(f, l) != f[7:1]);
        return e;
    endfunction

    // One SDCLK strobe carrying bit b; returns at the negedge of the cycle after it.
    task automatic strobe(input logic b);
        repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
            cmd = ($urandom_range(0, 1) != 0);
        end
        @(posedge clk); #1;
        cmd        = b;
        sdclk_rise = 1'b1;
        @(posedge clk); #1;
        sdclk_rise = 1'b0;
        cmd        = ($urandom_range(0, 1) != 0);
        @(negedge clk);
    endtask

    task automatic arm(input logic l, input logic c);
        @(posedge clk); #1;
        start = 1'b1;
        lng   = l;
        chk   = c;
        @(posedge clk); #1;
        start = 1'b0;
        lng   = ($urandom_range(0, 1) != 0);
        chk   = ($urandom_range(0, 1) != 0);
        @(negedge clk);
    endtask

    // Sends idle strobes then the frame; ends at the negedge of the done cycle.
    task automatic send_frame(input logic [135:0] f, input logic l, input int idle, output int early);
        int d0;
        int n;
        for (int i = 0; i < idle; i++) strobe(1'b1);
        d0 = done_cnt;
        n  = l ? 136 : 48;
        for (int i = n - 1; i >= 0; i--) strobe(f[i]);
        early = done_cnt - d0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sdclk_rise = 1'b0; cmd = 1'b1; start = 1'b0; lng = 1'b0; chk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (resp !== 128'd0) begin errors++; $display("FAIL reset_resp: got %h expected 0", resp); end
        checks++; if (index !== 6'd0) begin errors++; $display("FAIL reset_index: got %h expected 0", index); end
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_crc_err: got %b expected 0", crc_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        // Strobes while idle must be ignored.
        repeat (3) strobe(1'b0);
        checks++; if (busy !== 1'b0 || done_cnt != 0) begin errors++; $display("FAIL idle_ignore: got busy=%b dones=%0d expected 0/0", busy, done_cnt); end
    endtask

    task automatic test_r7();
        int early;
        arm(1'b0, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL r7_busy_rise: got %b expected 1", busy); end
        send_frame(136'h08_0000_01AA_13, 1'b0, 5, early);
        checks++; if (done !== 1'b1 || early != 0) begin errors++; $display("FAIL r7_done: got done=%b early=%0d expected 1/0", done, early); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL r7_busy_at_done: got %b expected 1", busy); end
        checks++; if (resp !== 128'h08_0000_01AA) begin errors++; $display("FAIL r7_resp: got %h expected %h", resp, 128'h08_0000_01AA); end
        checks++; if (index !== 6'h08) begin errors++; $display("FAIL r7_index: got %h expected 08", index); end
        checks++; if ({crc_err, frame_err, timeout} !== 3'b000) begin errors++; $display("FAIL r7_flags: got %b expected 000", {crc_err, frame_err, timeout}); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL r7_after: got done=%b busy=%b expected 0/0", done, busy); end
        repeat (4) @(negedge clk);
        checks++; if (resp !== 128'h08_0000_01AA || index !== 6'h08) begin errors++; $display("FAIL r7_hold: got %h/%h expected held payload", resp, index); end
    endtask

    task automatic test_r3();
        int early;
        arm(1'b0, 1'b0);
        send_frame(136'h3F_80FF_8000_FF, 1'b0, 2, early);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL r3_done: got %b expected 1", done); end
        checks++; if (index !== 6'h3F) begin errors++; $display("FAIL r3_index: got %h expected 3f", index); end
        checks++; if (resp !== 128'h3F_80FF_8000) begin errors++; $display("FAIL r3_resp: got %h expected %h", resp, 128'h3F_80FF_8000); end
        checks++; if ({crc_err, frame_err} !== 2'b00) begin errors++; $display("FAIL r3_flags: got %b expected 00", {crc_err, frame_err}); end
    endtask

    task automatic test_errors();
        int early;
        arm(1'b0, 1'b1);
        send_frame(136'h08_0000_01AB_13, 1'b0, 1, early);
        checks++; if (done !== 1'b1 || crc_err !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL crc_err: got done=%b crc=%b frame=%b expected 1/1/0", done, crc_err, frame_err); end
        arm(1'b0, 1'b1);
        send_frame(136'h08_0000_01AA_12, 1'b0, 0, early);
        checks++; if (done !== 1'b1 || crc_err !== 1'b0 || frame_err !== 1'b1) begin errors++; $display("FAIL end_bit: got done=%b crc=%b frame=%b expected 1/0/1", done, crc_err, frame_err); end
        arm(1'b0, 1'b1);
        send_frame(136'h48_0000_01AA_13, 1'b0, 0, early);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL trans_bit: got frame=%b expected 1", frame_err); end
    endtask

    task automatic test_timeout();
        int d0;
        int early;
        arm(1'b0, 1'b1);
        d0 = done_cnt;
        repeat (63) strobe(1'b1);
        checks++; if (done !== 1'b0 || done_cnt != d0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early: got done=%b dones=%0d busy=%b expected 0/%0d/1", done, done_cnt, busy, d0); end
        strobe(1'b1);
        checks++; if (done !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL tmo_done: got done=%b timeout=%b expected 1/1", done, timeout); end
        checks++; if (resp !== 128'd0 || index !== 6'd0 || crc_err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL tmo_payload: got %h/%h/%b/%b expected zeros", resp, index, crc_err, frame_err); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy_fall: got %b expected 0", busy); end
        // Start bit on the 64th strobe wins.
        arm(1'b0, 1'b1);
        repeat (63) strobe(1'b1);
        send_frame(136'h08_0000_01AA_13, 1'b0, 0, early);
        checks++; if (done !== 1'b1 || timeout !== 1'b0 || early != 0) begin errors++; $display("FAIL tmo_last_start: got done=%b timeout=%b early=%0d expected 1/0/0", done, timeout, early); end
        checks++; if (resp !== 128'h08_0000_01AA || crc_err !== 1'b0) begin errors++; $display("FAIL tmo_last_resp: got %h crc=%b expected %h crc=0", resp, crc_err, 128'h08_0000_01AA); end
    endtask

    task automatic test_start_ignored();
        logic [135:0] f;
        exp_t e;
        f = make_short(6'($urandom), $urandom);
        e = model(f, 1'b0, 1'b1);
        arm(1'b0, 1'b1);
        strobe(1'b1);
        for (int i = 47; i >= 38; i--) strobe(f[i]);
        @(posedge clk); #1;
        start = 1'b1; lng = 1'b1; chk = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_ign_busy: got %b expected 1", busy); end
        for (int i = 37; i >= 0; i--) strobe(f[i]);
        checks++; if (done !== 1'b1 || resp !== e.resp || index !== e.index) begin errors++; $display("FAIL start_ign: got done=%b %h/%h expected 1 %h/%h", done, resp, index, e.resp, e.index); end
        checks++; if (crc_err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL start_ign_flags: got %b%b expected 00", crc_err, frame_err); end
    endtask

    task automatic test_long();
        logic [135:0] f;
        int early;
        f = make_long({$urandom, $urandom, $urandom, 24'($urandom)});
        arm(1'b1, 1'b1);
        send_frame(f, 1'b1, 3, early);
        checks++; if (done !== 1'b1 || early != 0) begin errors++; $display("FAIL r2_done: got done=%b early=%0d expected 1/0", done, early); end
        checks++; if (crc_err !== 1'b0 || frame_err !== 1'b0 || index !== 6'h3F) begin errors++; $display("FAIL r2_status: got crc=%b frame=%b idx=%h expected 0/0/3f", crc_err, frame_err, index); end
        checks++; if (resp !== f[127:0]) begin errors++; $display("FAIL r2_resp: got %h expected %h", resp, f[127:0]); end
        f[8] = ~f[8];
        arm(1'b1, 1'b1);
        send_frame(f, 1'b1, 0, early);
        checks++; if (done !== 1'b1 || crc_err !== 1'b1) begin errors++; $display("FAIL r2_crc_err: got done=%b crc=%b expected 1/1", done, crc_err); end
        // Header bits are outside the CRC coverage.
        f[8] = ~f[8];
        f[130] = ~f[130];
        arm(1'b1, 1'b1);
        send_frame(f, 1'b1, 0, early);
        checks++; if (crc_err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL r2_header_excl: got crc=%b frame=%b expected 0/0", crc_err, frame_err); end
    endtask

    task automatic test_reset_mid();
        logic [135:0] f;
        int d0;
        f = make_short(6'($urandom), $urandom);
        arm(1'b0, 1'b1);
        for (int i = 47; i >= 28; i--) strobe(f[i]);
        d0 = done_cnt;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, crc_err, frame_err, timeout} !== 5'b0 || resp !== 128'd0 || index !== 6'd0) begin errors++; $display("FAIL reset_mid: got busy=%b done=%b resp=%h idx=%h expected all 0", busy, done, resp, index); end
        for (int i = 27; i >= 0; i--) strobe(f[i]);
        repeat (3) @(negedge clk);
        checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_nodone: got dones=%0d busy=%b expected %0d/0", done_cnt, busy, d0); end
    endtask

    task automatic test_back_to_back();
        logic [135:0] f;
        exp_t e;
        int early;
        f = make_short(6'($urandom), $urandom);
        e = model(f, 1'b0, 1'b1);
        arm(1'b0, 1'b1);
        send_frame(make_short(6'h11, 32'h1234_5678), 1'b0, 0, early);
        // start_i in the done cycle (long) must be dropped; the one a cycle later (short) is taken.
        start = 1'b1; lng = 1'b1; chk = 1'b0;
        @(posedge clk); #1;
        lng = 1'b0; chk = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall: got %b expected 0", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_rearm: got %b expected 1", busy); end
        send_frame(f, 1'b0, 1, early);
        checks++; if (done !== 1'b1 || resp !== e.resp || index !== e.index || crc_err !== 1'b0) begin errors++; $display("FAIL b2b_frame: got done=%b %h/%h crc=%b expected 1 %h/%h 0", done, resp, index, crc_err, e.resp, e.index); end
    endtask

    task automatic test_random();
        logic [135:0] f;
        logic l;
        logic c;
        exp_t e;
        int early;
        int n;
        for (int it = 0; it < 14; it++) begin
            l = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 3) != 0);
            f = l ? make_long({$urandom, $urandom, $urandom, 24'($urandom)}) : make_short(6'($urandom), $urandom);
            n = l ? 136 : 48;
            if ($urandom_range(0, 1) != 0) begin
                int k;
                k = $urandom_range(0, n - 2);
                f[k] = ~f[k];
            end
            e = model(f, l, c);
            arm(l, c);
            send_frame(f, l, $urandom_range(0, 8), early);
            checks++; if (done !== 1'b1 || early != 0 || timeout !== 1'b0) begin errors++; $display("FAIL rnd%0d_done: got done=%b early=%0d tmo=%b expected 1/0/0", it, done, early, timeout); end
            checks++; if (resp !== e.resp || index !== e.index) begin errors++; $display("FAIL rnd%0d_payload: got %h/%h expected %h/%h", it, resp, index, e.resp, e.index); end
            checks++; if (crc_err !== e.crc_err || frame_err !== e.frame_err) begin errors++; $display("FAIL rnd%0d_flags: got crc=%b frame=%b expected %b/%b", it, crc_err, frame_err, e.crc_err, e.frame_err); end
        end
    endtask

    initial begin
        test_reset();
        test_r7();
        test_r3();
        test_errors();
        test_timeout();
        test_start_ignored();
        test_long();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
